// File: rtl/keypad_scan_if.sv
// Keypad scanner bus: column sense lines in, row drive and decoded key out.
interface keypad_scan_if;
   logic [3:0] key_col;
   logic [3:0] key_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   // Scanner side: reads columns, drives rows and the key report.
   modport master (
      input  key_col,
      output key_row,
      output key_code,
      output key_valid,
      output key_held
   );

   // Keypad / consumer side.
   modport slave (
      output key_col,
      input  key_row,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad row scanner with press/release debounce.
// Rows are walked one-hot active-low, columns are read back through a
// 2-flop synchronizer and sampled once per scan tick.
module keypad_scan #(
   parameter int SCAN_DIV       = 10000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   keypad_scan_if.master kp
);

   localparam int         CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   logic [3:0]    col_m_reg;
   logic [3:0]    col_s_reg;
   logic [CW-1:0] div_cnt_reg;
   logic          tick;
   logic [1:0]    col_idx;
   logic          col_idle;
   logic [3:0]    deb_inc;

   state_t        state_reg;
   logic [3:0]    row_reg;
   logic [1:0]    row_idx_reg;
   logic [3:0]    pat_reg;
   logic [3:0]    deb_cnt_reg;
   logic [3:0]    key_code_reg;
   logic          key_valid_reg;
   logic          key_held_reg;

   // Two-flop synchronizer for the asynchronous column lines (idle = all high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_m_reg <= 4'b1111;
         col_s_reg <= 4'b1111;
      end else begin
         col_m_reg <= kp.key_col;
         col_s_reg <= col_m_reg;
      end
   end

   // Free-running scan divider; the tick marks the column sampling cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_reg <= '0;
      end else if (tick) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

   assign tick     = (div_cnt_reg == CW'(SCAN_DIV - 1));
   assign col_idle = (col_s_reg == 4'b1111);
   assign deb_inc  = deb_cnt_reg + 4'd1;

   // Lowest-index active column wins when several are low.
   always_comb begin
      col_idx = 2'd0;
      if (!col_s_reg[0])      col_idx = 2'd0;
      else if (!col_s_reg[1]) col_idx = 2'd1;
      else if (!col_s_reg[2]) col_idx = 2'd2;
      else if (!col_s_reg[3]) col_idx = 2'd3;
   end

   // Scan / debounce / held / release state machine; the row only moves in SCAN
   // or when a release completes, so a held key stays on its row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= SCAN;
         row_reg       <= 4'b1110;
         row_idx_reg   <= 2'd0;
         pat_reg       <= 4'b1111;
         deb_cnt_reg   <= 4'd0;
         key_code_reg  <= 4'h0;
         key_valid_reg <= 1'b0;
         key_held_reg  <= 1'b0;
      end else begin
         key_valid_reg <= 1'b0;
         if (tick) begin
            case (state_reg)
               SCAN: begin
                  if (col_idle) begin
                     row_reg     <= {row_reg[2:0], row_reg[3]};
                     row_idx_reg <= row_idx_reg + 2'd1;
                  end else begin
                     pat_reg     <= col_s_reg;
                     deb_cnt_reg <= 4'd1;
                     if (DT == 4'd1) begin
                        state_reg     <= PRESSED;
                        key_code_reg  <= {row_idx_reg, col_idx};
                        key_valid_reg <= 1'b1;
                        key_held_reg  <= 1'b1;
                     end else begin
                        state_reg <= DEBOUNCE;
                     end
                  end
               end
               DEBOUNCE: begin
                  if (col_idle) begin
                     state_reg <= SCAN;
                  end else if (col_s_reg == pat_reg || DT == 4'd1) begin
                     // A changed pattern with a one-tick window still accepts at once.
                     pat_reg     <= col_s_reg;
                     deb_cnt_reg <= (col_s_reg == pat_reg) ? deb_inc : 4'd1;
                     if (col_s_reg != pat_reg || deb_inc == DT) begin
                        state_reg     <= PRESSED;
                        key_code_reg  <= {row_idx_reg, col_idx};
                        key_valid_reg <= 1'b1;
                        key_held_reg  <= 1'b1;
                     end
                  end else begin
                     pat_reg     <= col_s_reg;
                     deb_cnt_reg <= 4'd1;
                  end
               end
               PRESSED: begin
                  if (col_idle) begin
                     deb_cnt_reg <= 4'd1;
                     if (DT == 4'd1) begin
                        state_reg    <= SCAN;
                        key_held_reg <= 1'b0;
                        row_reg      <= {row_reg[2:0], row_reg[3]};
                        row_idx_reg  <= row_idx_reg + 2'd1;
                     end else begin
                        state_reg <= RELEASE;
                     end
                  end
               end
               RELEASE: begin
                  if (!col_idle) begin
                     state_reg <= PRESSED;
                  end else begin
                     deb_cnt_reg <= deb_inc;
                     if (deb_inc == DT) begin
                        state_reg    <= SCAN;
                        key_held_reg <= 1'b0;
                        row_reg      <= {row_reg[2:0], row_reg[3]};
                        row_idx_reg  <= row_idx_reg + 2'd1;
                     end
                  end
               end
               default: state_reg <= SCAN;
            endcase
         end
      end
   end

   assign kp.key_row   = row_reg;
   assign kp.key_code  = key_code_reg;
   assign kp.key_valid = key_valid_reg;
   assign kp.key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix.
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, column c

   keypad_scan_if kp ();

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key shorts its column to its row when that row is driven low.
   always_comb begin
      kp.key_col = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp.key_row[r]) kp.key_col[c] = 1'b0;
   end

   typedef struct {
      logic [15:0] press;
      int          cycles;
      int          pulses;
      int          code;
      int          held;
   } vec_t;

   vec_t vt [8];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   p;
   int   tot;
   int   held_low;
   bit   found;

   function automatic logic [15:0] k(input int r, input int c);
      return 16'(1) << (r*4 + c);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Run n cycles, counting cycles with key_valid high.
   task automatic run(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (kp.key_valid) pulses++;
      end
   endtask

   initial begin
      vt[0] = '{k(2,1),          40, 1, 9,  1};
      vt[1] = '{16'h0000,        20, 0, 9,  0};
      vt[2] = '{k(1,3) | k(1,0), 40, 1, 4,  1};
      vt[3] = '{k(1,3),          20, 0, 4,  1};
      vt[4] = '{16'h0000,        20, 0, 4,  0};
      vt[5] = '{k(0,0),          40, 1, 0,  1};
      vt[6] = '{16'h0000,        20, 0, 0,  0};
      vt[7] = '{k(3,2),          40, 1, 14, 1};

      // Reset asserted mid-count, then row stepping after release.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst row", kp.key_row, 4'b1110);
      chk("rst valid", kp.key_valid, 0);
      chk("rst held", kp.key_held, 0);
      chk("rst code", kp.key_code, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("row hold 3 cyc", kp.key_row, 4'b1110);
      @(posedge clk);
      #1 chk("row step 4 cyc", kp.key_row, 4'b1101);
      repeat (4) @(posedge clk);
      #1 chk("row step 8 cyc", kp.key_row, 4'b1011);
      repeat (12) @(posedge clk);
      #1 chk("row period 16", kp.key_row, 4'b1101);

      // Table of press/release phases.
      for (int i = 0; i < 8; i++) begin
         pressed = vt[i].press;
         run(vt[i].cycles, p);
         chk($sformatf("vec%0d pulses", i), p, vt[i].pulses);
         chk($sformatf("vec%0d code", i), kp.key_code, vt[i].code);
         chk($sformatf("vec%0d held", i), kp.key_held, vt[i].held);
      end

      // Reset while a key is held clears outputs immediately.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midop rst code", kp.key_code, 0);
      chk("midop rst held", kp.key_held, 0);
      chk("midop rst row", kp.key_row, 4'b1110);
      pressed = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;

      // Single press: after release debounce, scanning resumes on row 3.
      pressed = k(2,1);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (kp.key_held) found = 1'b1;
      end
      chk("single held rise", found, 1);
      pressed = 16'h0000;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (!kp.key_held) found = 1'b1;
      end
      chk("single held fall", found, 1);
      chk("single resume row3", kp.key_row, 4'b0111);
      chk("single code", kp.key_code, 9);
      run(10, p);

      // Bounce: toggle every 5 cycles for 30 cycles, then hold.
      tot = 0;
      for (int t = 0; t < 6; t++) begin
         pressed = (t % 2 == 0) ? k(2,1) : 16'h0000;
         run(5, p);
         tot += p;
      end
      chk("bounce pulses", tot, 0);
      chk("bounce held", kp.key_held, 0);
      pressed = k(2,1);
      run(40, p);
      chk("bounce stable pulses", p, 1);
      pressed = 16'h0000;
      run(20, p);
      chk("bounce release held", kp.key_held, 0);

      // Release glitch: one low tick during RELEASE returns to PRESSED.
      pressed = k(1,0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (kp.key_valid) found = 1'b1;
      end
      chk("glitch accept", found, 1);
      chk("glitch code", kp.key_code, 4);
      tot = 0;
      held_low = 0;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i == 1) pressed = 16'h0000;
         if (i == 5) pressed = k(1,0);
         if (i == 9) pressed = 16'h0000;
         if (kp.key_valid) tot++;
         if (!kp.key_held) held_low++;
      end
      chk("glitch extra pulses", tot, 0);
      chk("glitch held low cycles", held_low, 0);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (!kp.key_held) found = 1'b1;
      end
      chk("glitch final release", found, 1);
      run(8, p);

      // Reset during DEBOUNCE after two stable ticks.
      @(negedge clk);
      rst_n = 1'b0;
      pressed = k(0,2);
      @(negedge clk);
      rst_n = 1'b1;
      run(8, p);
      chk("deb pre-reset pulses", p, 0);
      rst_n = 1'b0;
      #1;
      chk("deb rst row", kp.key_row, 4'b1110);
      chk("deb rst valid", kp.key_valid, 0);
      chk("deb rst held", kp.key_held, 0);
      pressed = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      run(30, p);
      chk("deb post-reset pulses", p, 0);
      pressed = k(0,2);
      run(40, p);
      chk("deb fresh pulses", p, 1);
      chk("deb fresh code", kp.key_code, 2);
      chk("deb fresh held", kp.key_held, 1);
      pressed = 16'h0000;
      run(20, p);
      chk("deb fresh release", kp.key_held, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Row-scanning reader for a 4x4 matrix keypad. It is the input-side counterpart of the multiplexed seven-segment driver: the driver walks digit-select lines and pushes segment data out, and this block walks row-select lines and reads column lines back in. Key presses are debounced and reported as a 4-bit code with a one-cycle strobe, which feeds the BCD/value registers that the display path shows.

## Interface
- SCAN_DIV, default 10000: clk cycles per scan tick; rows advance and columns are sampled once per tick; must be ≥ 4.
- DEBOUNCE_TICKS, default 4: number of consecutive ticks a press or release must be stable; range 1..15.
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- key_col, input, 4: column lines, pulled up, active-low (bit c low means a key in column c of the driven row is pressed); asynchronous to clk.
- key_row, output, 4: row drive, one-hot active-low (exactly one bit low at all times).
- key_code, output, 4: {row_idx[1:0], col_idx[1:0]} of the last accepted key; holds its value until the next accept.
- key_valid, output, 1: one-cycle pulse when key_code is updated.
- key_held, output, 1: high while the accepted key remains debounced as pressed.

## Operation
- Input sync: key_col goes through a 2-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value col_s.
- Tick counter: 0..SCAN_DIV-1, free-running. `tick` is high for one cycle when the count equals SCAN_DIV-1.
- Column priority: if more than one bit of col_s is low, the lowest-index low column is used (col_idx). The pattern compared for stability is the full 4-bit col_s.
- FSM states and transitions:
  - SCAN: on tick, if col_s == 4'b1111, rotate row (1110→1101→1011→0111→1110; row_idx 0→1→2→3→0). Otherwise latch pat=col_s, set deb_cnt=1 and go to DEBOUNCE with the row held.
  - DEBOUNCE: on tick, if col_s == pat, deb_cnt++. If col_s is all-ones, return to SCAN without rotating. If col_s differs from pat but is not all-ones, set pat=col_s and deb_cnt=1. When deb_cnt reaches DEBOUNCE_TICKS, go to PRESSED.
  - PRESSED (entry): key_code={row_idx,col_idx}, key_valid=1 for exactly one cycle, key_held=1. On tick, if col_s == 4'b1111, set deb_cnt=1 and go to RELEASE. Changes in col_s that are not all-ones are ignored; no new accept occurs.
  - RELEASE: on tick, if col_s == 4'b1111, deb_cnt++. Otherwise go back to PRESSED without a new key_valid. When deb_cnt reaches DEBOUNCE_TICKS, set key_held=0, rotate row and go to SCAN.
- With DEBOUNCE_TICKS=1, the first tick that sees the press accepts it directly (SCAN→PRESSED path through DEBOUNCE in the same tick). Same rule for release.
- The row never changes outside SCAN, so the held key stays observable.

## Timing
- Reset (async assert, sync release): state=SCAN, key_row=4'b1110, key_code=4'h0, key_valid=0, key_held=0, tick counter=0, deb_cnt=0, synchronizer=4'b1111.
- Reset mid-operation: all of the above values are applied immediately; a pending accept is dropped and no key_valid is emitted.
- Each row is driven for a full SCAN_DIV cycles before it is sampled, which gives the lines time to settle.
- Sampling happens on the tick cycle. The row change and state change take effect on the following clk edge.
- key_valid is registered: it asserts on the cycle after the tick on which deb_cnt reaches DEBOUNCE_TICKS. key_code and key_held update on that same edge.
- Worst-case press-to-valid latency: 2 (sync) + 4·SCAN_DIV (row search) + (DEBOUNCE_TICKS−1)·SCAN_DIV + 1 cycles.
- key_held falls on the same edge relative to its qualifying tick as key_valid rises.

## Test plan
(SCAN_DIV=4, DEBOUNCE_TICKS=3 for all cases.)
- Reset: assert rst_n=0 mid-count → key_row=1110, key_valid=0, key_held=0, key_code=0 immediately. After release, key_row steps 1110→1101 after 4 clk cycles, then repeats with a period of 16 cycles.
- Single press: model key (row 2, col 1) by pulling key_col[1] low while key_row[2]=0, held 40 cycles → exactly one key_valid pulse with key_code=4'h9. key_held=1 until 3 ticks after release, then scanning resumes from row 3.
- Bounce: toggle the press every 5 cycles for 30 cycles, then hold it → no key_valid during toggling, then exactly one key_valid once the press has been stable for 3 ticks.
- Two keys: press (row 1, col 3) and (row 1, col 0) together → key_code=4'h4 (col 0 wins), one pulse. Releasing col 0 only → no new pulse and key_held stays 1.
- Release glitch: while in RELEASE, pull the column low for one tick → FSM returns to PRESSED, no second key_valid, and key_held stays 1 throughout.
- Reset during DEBOUNCE: assert rst_n after 2 stable ticks → no key_valid, key_row=1110, and a fresh press is needed to get a pulse.
